// File: rtl/dso100fb_dither.sv
// Panel output stage: reduces 8-bit RGB to OUT_BITS per colour with 4x4 ordered
// dithering (optionally rotated per frame) and realigns syncs through 2 registers.
module dso100fb_dither #(
  parameter int OUT_BITS = 6
) (
  input  logic                VIDCLK,
  input  logic                RST,
  input  logic [31:0]         VID_DATA,
  input  logic                VID_DE,
  input  logic                VID_HSYNC,
  input  logic                VID_VSYNC,
  input  logic                DE_POLARITY,
  input  logic                VSYNC_POLARITY,
  input  logic                DITHER_EN,
  input  logic                TEMPORAL_EN,
  output logic [OUT_BITS-1:0] LCD_R,
  output logic [OUT_BITS-1:0] LCD_G,
  output logic [OUT_BITS-1:0] LCD_B,
  output logic                LCD_DE,
  output logic                LCD_HSYNC,
  output logic                LCD_VSYNC
);

  localparam int D = 8 - OUT_BITS;

  logic        w_de_act, w_vs_act, w_fs, w_de_fall;
  logic        r_vs_act, r_de_prev;
  logic [11:0] r_x, r_y;
  logic [1:0]  r_frame;
  logic        r_dith, r_temp;
  logic [1:0]  w_xi, w_yi;
  logic [3:0]  w_bayer, w_add;

  logic [23:0] r1_data;
  logic        r1_de, r1_hs, r1_vs, r1_de_act;
  logic [3:0]  r1_add;

  logic [OUT_BITS-1:0] w_r, w_g, w_b;
  logic [OUT_BITS-1:0] r_lcd_r, r_lcd_g, r_lcd_b;
  logic                r_lcd_de, r_lcd_hs, r_lcd_vs;

  assign w_de_act  = VID_DE ~^ DE_POLARITY;
  assign w_vs_act  = VID_VSYNC ~^ VSYNC_POLARITY;
  assign w_fs      = w_vs_act & ~r_vs_act;
  assign w_de_fall = ~w_de_act & r_de_prev;

  // Temporal mode shifts both matrix coordinates by the frame number (mod 4).
  assign w_xi = r_temp ? (r_x[1:0] + r_frame) : r_x[1:0];
  assign w_yi = r_temp ? (r_y[1:0] + r_frame) : r_y[1:0];

  always_comb begin
    w_bayer = 4'd0;
    case ({w_yi, w_xi})
      4'h0: w_bayer = 4'd0;   4'h1: w_bayer = 4'd8;
      4'h2: w_bayer = 4'd2;   4'h3: w_bayer = 4'd10;
      4'h4: w_bayer = 4'd12;  4'h5: w_bayer = 4'd4;
      4'h6: w_bayer = 4'd14;  4'h7: w_bayer = 4'd6;
      4'h8: w_bayer = 4'd3;   4'h9: w_bayer = 4'd11;
      4'hA: w_bayer = 4'd1;   4'hB: w_bayer = 4'd9;
      4'hC: w_bayer = 4'd15;  4'hD: w_bayer = 4'd7;
      4'hE: w_bayer = 4'd13;  4'hF: w_bayer = 4'd5;
      default: w_bayer = 4'd0;
    endcase
  end

  assign w_add = r_dith ? (w_bayer >> (4 - D)) : 4'd0;

  function automatic logic [OUT_BITS-1:0] sat_shift(input logic [7:0] c, input logic [3:0] a);
    logic [8:0] s;
    s = {1'b0, c} + {5'd0, a};
    if (s[8]) s = 9'd255;
    return s[7:D];
  endfunction

  assign w_r = sat_shift(r1_data[23:16], r1_add);
  assign w_g = sat_shift(r1_data[15:8],  r1_add);
  assign w_b = sat_shift(r1_data[7:0],   r1_add);

  always_ff @(posedge VIDCLK or posedge RST) begin
    if (RST) begin
      r_vs_act  <= 1'b0;
      r_de_prev <= 1'b0;
      r_x       <= 12'd0;
      r_y       <= 12'd0;
      r_frame   <= 2'd0;
      r_dith    <= 1'b0;
      r_temp    <= 1'b0;
      r1_data   <= 24'd0;
      r1_de     <= 1'b0;
      r1_hs     <= 1'b0;
      r1_vs     <= 1'b0;
      r1_de_act <= 1'b0;
      r1_add    <= 4'd0;
      r_lcd_r   <= '0;
      r_lcd_g   <= '0;
      r_lcd_b   <= '0;
      r_lcd_de  <= 1'b0;
      r_lcd_hs  <= 1'b0;
      r_lcd_vs  <= 1'b0;
    end else begin
      r_vs_act  <= w_vs_act;
      r_de_prev <= w_de_act;
      r_x       <= w_de_act ? r_x + 12'd1 : 12'd0;
      // Frame-start clear wins over a coincident end-of-line increment.
      if (w_fs)           r_y <= 12'd0;
      else if (w_de_fall) r_y <= r_y + 12'd1;
      if (w_fs) begin
        r_frame <= r_frame + 2'd1;
        r_dith  <= DITHER_EN;
        r_temp  <= TEMPORAL_EN;
      end
      r1_data   <= VID_DATA[23:0];
      r1_de     <= VID_DE;
      r1_hs     <= VID_HSYNC;
      r1_vs     <= VID_VSYNC;
      r1_de_act <= w_de_act;
      r1_add    <= w_add;
      r_lcd_r   <= r1_de_act ? w_r : '0;
      r_lcd_g   <= r1_de_act ? w_g : '0;
      r_lcd_b   <= r1_de_act ? w_b : '0;
      r_lcd_de  <= r1_de;
      r_lcd_hs  <= r1_hs;
      r_lcd_vs  <= r1_vs;
    end
  end

  assign LCD_R     = r_lcd_r;
  assign LCD_G     = r_lcd_g;
  assign LCD_B     = r_lcd_b;
  assign LCD_DE    = r_lcd_de;
  assign LCD_HSYNC = r_lcd_hs;
  assign LCD_VSYNC = r_lcd_vs;

endmodule

// File: tb/tb_dso100fb_dither.sv
// Bench for dso100fb_dither: per-cycle comparison against a pixel-level model
// plus hand-computed literal colour values on selected pixels.
module tb_dso100fb_dither;

  localparam int OB = 6;
  localparam int D  = 8 - OB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [31:0]   vid_data = 32'd0;
  logic          vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic          de_pol = 1'b1, vs_pol = 1'b1;
  logic          dith_en = 1'b0, temp_en = 1'b0;
  logic [OB-1:0] lcd_r, lcd_g, lcd_b;
  logic          lcd_de, lcd_hs, lcd_vs;
  int            lit_r = -1, lit_g = -1, lit_b = -1;

  int n_vec  = 0;
  int n_miss = 0;

  dso100fb_dither #(.OUT_BITS(OB)) dut (
    .VIDCLK(clk), .RST(rst), .VID_DATA(vid_data), .VID_DE(vid_de),
    .VID_HSYNC(vid_hs), .VID_VSYNC(vid_vs), .DE_POLARITY(de_pol),
    .VSYNC_POLARITY(vs_pol), .DITHER_EN(dith_en), .TEMPORAL_EN(temp_en),
    .LCD_R(lcd_r), .LCD_G(lcd_g), .LCD_B(lcd_b),
    .LCD_DE(lcd_de), .LCD_HSYNC(lcd_hs), .LCD_VSYNC(lcd_vs)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pixel-level model ----------------
  typedef struct {int de; int hs; int vs; int r; int g; int b; int lr; int lg; int lb;} exp_t;
  exp_t hist[$];
  exp_t cur_exp;
  int   bt[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  int   m_prev_vs, m_prev_de, m_px, m_line, m_frame, m_dith, m_temp;

  function automatic int chan(input int c, input int add);
    int s;
    s = c + add;
    if (s > 255) s = 255;
    return s >> D;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    int   de_act, vs_act, add, row, col;
    if (rst) begin
      e = '{default: 0};
      e.lr = -1; e.lg = -1; e.lb = -1;
      hist = {};
      hist.push_back(e);
      cur_exp = e;
      m_prev_vs = 0; m_prev_de = 0; m_px = 0; m_line = 0;
      m_frame = 0; m_dith = 0; m_temp = 0;
    end else begin
      de_act = (vid_de == de_pol) ? 1 : 0;
      vs_act = (vid_vs == vs_pol) ? 1 : 0;
      row = m_temp ? (m_line + m_frame) % 4 : m_line % 4;
      col = m_temp ? (m_px + m_frame) % 4 : m_px % 4;
      add = m_dith ? (bt[row * 4 + col] >> (4 - D)) : 0;
      e.de = int'(vid_de); e.hs = int'(vid_hs); e.vs = int'(vid_vs);
      e.r  = de_act ? chan(int'(vid_data[23:16]), add) : 0;
      e.g  = de_act ? chan(int'(vid_data[15:8]),  add) : 0;
      e.b  = de_act ? chan(int'(vid_data[7:0]),   add) : 0;
      e.lr = lit_r; e.lg = lit_g; e.lb = lit_b;
      hist.push_back(e);
      cur_exp = hist.pop_front();
      m_px = de_act ? m_px + 1 : 0;
      if (vs_act && !m_prev_vs) begin
        m_line  = 0;
        m_frame = (m_frame + 1) % 4;
        m_dith  = int'(dith_en);
        m_temp  = int'(temp_en);
      end else if (!de_act && m_prev_de) begin
        m_line = m_line + 1;
      end
      m_prev_vs = vs_act;
      m_prev_de = de_act;
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #4;
    check("lcd_de", int'(lcd_de), cur_exp.de);
    check("lcd_hs", int'(lcd_hs), cur_exp.hs);
    check("lcd_vs", int'(lcd_vs), cur_exp.vs);
    check("lcd_r",  int'(lcd_r),  cur_exp.r);
    check("lcd_g",  int'(lcd_g),  cur_exp.g);
    check("lcd_b",  int'(lcd_b),  cur_exp.b);
    if (cur_exp.lr >= 0) check("lit_r", int'(lcd_r), cur_exp.lr);
    if (cur_exp.lg >= 0) check("lit_g", int'(lcd_g), cur_exp.lg);
    if (cur_exp.lb >= 0) check("lit_b", int'(lcd_b), cur_exp.lb);
  end

  // ---------------- driver tasks ----------------
  task automatic px(input logic [31:0] d, input logic de, input logic hs, input logic vs,
                    input int lr = -1, input int lg = -1, input int lb = -1);
    @(negedge clk);
    vid_data = d; vid_de = de; vid_hs = hs; vid_vs = vs;
    lit_r = lr; lit_g = lg; lit_b = lb;
  endtask

  task automatic blank(input int n, input logic hs);
    for (int i = 0; i < n; i++) px(32'h0, 1'b0, hs, ~vs_pol);
  endtask

  task automatic vpulse();
    px(32'h0, 1'b0, 1'b0, vs_pol);
    px(32'h0, 1'b0, 1'b0, vs_pol);
    blank(2, 1'b0);
  endtask

  task automatic do_reset(input logic new_vs_pol);
    @(negedge clk);
    rst = 1'b1; vs_pol = new_vs_pol; vid_vs = ~new_vs_pol; vid_de = 1'b0;
    lit_r = -1; lit_g = -1; lit_b = -1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_line0[4] = '{'h20, 'h21, 'h20, 'h21};
  int exp_temp[4]  = '{'h21, 'h20, 'h21, 'h20};
  logic [31:0] mix_tab[6] = '{32'hFF12FEFD, 32'h00010203, 32'h00FCFDFE, 32'h007F8081, 32'h00FFFFFF, 32'h00414243};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_r", int'(lcd_r), 0);
    check("rst_de", int'(lcd_de), 0);
    check("rst_vs", int'(lcd_vs), 0);
    @(negedge clk);
    rst = 1'b0;

    // truncation
    blank(3, 1'b1);
    px(32'h00837F40, 1'b1, 1'b0, 1'b0, 'h20, 'h1F, 'h10);
    blank(4, 1'b1);

    // spatial dither, lines y=0 and y=1
    dith_en = 1'b1;
    vpulse();
    for (int i = 0; i < 4; i++) px(32'h00830000, 1'b1, 1'b0, 1'b0, exp_line0[i]);
    blank(3, 1'b1);
    for (int i = 0; i < 4; i++) px(32'h00830000, 1'b1, 1'b0, 1'b0, 'h21);
    blank(3, 1'b0);
    for (int i = 0; i < 6; i++) px(mix_tab[i], 1'b1, 1'b0, 1'b0);
    blank(3, 1'b1);

    // saturation at x=1, y=0
    vpulse();
    px(32'h00830000, 1'b1, 1'b0, 1'b0, 'h20);
    px(32'h00FF0000, 1'b1, 1'b0, 1'b0, 'h3F, 'h00, 'h00);
    blank(3, 1'b0);

    // temporal rotation across frames 1,2,3,0
    do_reset(1'b1);
    dith_en = 1'b1; temp_en = 1'b1;
    blank(2, 1'b0);
    for (int f = 0; f < 4; f++) begin
      vpulse();
      px(32'h00830000, 1'b1, 1'b0, 1'b0, exp_temp[f]);
      blank(3, 1'b1);
    end

    // mid-frame DITHER_EN change with active-low vsync
    dith_en = 1'b0; temp_en = 1'b0;
    do_reset(1'b0);
    blank(2, 1'b0);
    vpulse();
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h20);
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h20);
    dith_en = 1'b1;
    blank(3, 1'b1);
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h20);
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h20);
    blank(3, 1'b0);
    vpulse();
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h20);
    px(32'h00830000, 1'b1, 1'b0, 1'b1, 'h21);

    // reset during active video: outputs clear without a clock edge
    px(32'h00FFFFFF, 1'b1, 1'b1, 1'b1);
    px(32'h00FFFFFF, 1'b1, 1'b1, 1'b1);
    px(32'h00FFFFFF, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst_r", int'(lcd_r), 'h3F);
    rst = 1'b1;
    #1;
    check("async_rst_r", int'(lcd_r), 0);
    check("async_rst_de", int'(lcd_de), 0);
    check("async_rst_hs", int'(lcd_hs), 0);
    vs_pol = 1'b1; vid_vs = 1'b0; vid_de = 1'b0; vid_hs = 1'b0;
    lit_r = -1; lit_g = -1; lit_b = -1;
    @(negedge clk);
    rst = 1'b0;
    blank(2, 1'b0);
    px(32'h00837F40, 1'b1, 1'b0, 1'b0, 'h20, 'h1F, 'h10);
    blank(4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
